rob_commit_controller: RTL

In-order reorder-buffer controller for the out-of-order core.
- Allocates ROB tags to dispatched instructions and drives the register file's rename-allocation port (rob_entry_alloc / rob_alloc_rd_index / rob_alloc_tag).
- Captures results broadcast on the CDB.
- Retires entries in program order through the register file's commit write port (write_en / rd_index / rd / rd_rob_index).

---
 rtl/rob_commit_controller.sv | 118 +++++++++++
 1 files changed

// File: rtl/rob_commit_controller.sv
// rtl/rob_commit_controller.sv - in-order reorder-buffer allocate / capture / commit controller
// Optional ROB_BYPASS_COMMIT_EN: head entry may commit in the same cycle its CDB result arrives.
module rob_commit_controller #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic                     dispatch_writes_rd,
  input  logic [4:0]               dispatch_rd_index,
  output logic [ROB_TAG_WIDTH-1:0] dispatch_tag,
  output logic                     rob_entry_alloc,
  output logic [4:0]               rob_alloc_rd_index,
  output logic [ROB_TAG_WIDTH-1:0] rob_alloc_tag,
  input  logic                     cdb_valid,
  input  logic [ROB_TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]          cdb_value,
  output logic                     write_en,
  output logic [4:0]               rd_index,
  output logic [XLEN-1:0]          rd,
  output logic [ROB_TAG_WIDTH-1:0] rd_rob_index,
  input  logic                     flush,
  output logic [ROB_TAG_WIDTH:0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int DEPTH = 1 << ROB_TAG_WIDTH;
  localparam logic [ROB_TAG_WIDTH-1:0] TAG_ONE  = {{(ROB_TAG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ROB_TAG_WIDTH:0]   CNT_ONE  = {{ROB_TAG_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_TAG_WIDTH:0]   CNT_FULL = {1'b1, {ROB_TAG_WIDTH{1'b0}}};

  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         done_q;
  logic [DEPTH-1:0]         wr_q;
  logic [4:0]               rd_q  [DEPTH];
  logic [XLEN-1:0]          val_q [DEPTH];
  logic [ROB_TAG_WIDTH-1:0] head_q;
  logic [ROB_TAG_WIDTH-1:0] tail_q;
  logic [ROB_TAG_WIDTH:0]   count_q;

  logic            handshake;
  logic            commit;
  logic            bypass_hit;
  logic [XLEN-1:0] head_value;

  assign count          = count_q;
  assign full           = (count_q == CNT_FULL);
  assign empty          = (count_q == '0);
  assign dispatch_ready = !full && !flush;
  assign dispatch_tag   = tail_q;

  // Gated by reset so the register file never sees an allocation while we are held in reset.
  assign handshake          = reset && dispatch_valid && dispatch_ready;
  assign rob_entry_alloc    = handshake && dispatch_writes_rd && (dispatch_rd_index != 5'd0);
  assign rob_alloc_rd_index = rob_entry_alloc ? dispatch_rd_index : 5'd0;
  assign rob_alloc_tag      = rob_entry_alloc ? tail_q : '0;

`ifdef ROB_BYPASS_COMMIT_EN
  assign bypass_hit = busy_q[head_q] && !done_q[head_q] && cdb_valid && (cdb_tag == head_q);
  assign head_value = done_q[head_q] ? val_q[head_q] : cdb_value;
`else
  assign bypass_hit = 1'b0;
  assign head_value = val_q[head_q];
`endif

  assign commit       = reset && !flush && busy_q[head_q] && (done_q[head_q] || bypass_hit);
  assign write_en     = commit && wr_q[head_q] && (rd_q[head_q] != 5'd0);
  assign rd_index     = commit ? rd_q[head_q] : 5'd0;
  assign rd           = commit ? head_value : '0;
  assign rd_rob_index = commit ? head_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      done_q  <= '0;
      wr_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= 5'd0;
        val_q[i] <= '0;
      end
    end else if (flush) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // A tail entry being dispatched is never busy, so the CDB and dispatch never collide.
      if (cdb_valid && busy_q[cdb_tag]) begin
        done_q[cdb_tag] <= 1'b1;
        val_q[cdb_tag]  <= cdb_value;
      end
      if (commit) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + TAG_ONE;
      end
      if (handshake) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        wr_q[tail_q]   <= dispatch_writes_rd;
        rd_q[tail_q]   <= dispatch_rd_index;
        tail_q         <= tail_q + TAG_ONE;
      end
      if (handshake && !commit) begin
        count_q <= count_q + CNT_ONE;
      end else if (!handshake && commit) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

endmodule
